// File: rtl/taxi_apb_if.sv
// APB bus bundle with user sideband signals; mst drives the request side, slv the response side.
// Pure wiring: no latency, no storage; flow control is the APB psel/penable/pready handshake.
interface taxi_apb_if #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int STRB_W   = DATA_W / 8,
   parameter int PAUSER_W = 1,
   parameter int PWUSER_W = 1,
   parameter int PRUSER_W = 1,
   parameter int PBUSER_W = 1
) ();
   logic [ADDR_W-1:0]   paddr;
   logic [2:0]          pprot;
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [DATA_W-1:0]   pwdata;
   logic [STRB_W-1:0]   pstrb;
   logic [PAUSER_W-1:0] pauser;
   logic [PWUSER_W-1:0] pwuser;
   logic                pready;
   logic [DATA_W-1:0]   prdata;
   logic                pslverr;
   logic [PRUSER_W-1:0] pruser;
   logic [PBUSER_W-1:0] pbuser;

   modport mst (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
      input  pready, prdata, pslverr, pruser, pbuser
   );

   modport slv (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
      output pready, prdata, pslverr, pruser, pbuser
   );
endinterface

// File: rtl/taxi_apb_arb.sv
// Registered APB arbiter: PORTS requesters share one completer; 4 cycles per zero-wait transfer.
// Losing requesters stall with psel held; each downstream wait state adds one cycle.
module taxi_apb_arb #(
   parameter int PORTS           = 2,
   parameter bit ARB_ROUND_ROBIN = 1'b1,
   localparam int IDX_W          = PORTS > 1 ? $clog2(PORTS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   taxi_apb_if.slv          s_apb [PORTS],
   taxi_apb_if.mst          m_apb,
   output logic             busy,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_index
);
   localparam int DATA_W   = $bits(m_apb.pwdata);
   localparam int ADDR_W   = $bits(m_apb.paddr);
   localparam int STRB_W   = $bits(m_apb.pstrb);
   localparam int PAUSER_W = $bits(m_apb.pauser);
   localparam int PWUSER_W = $bits(m_apb.pwuser);
   localparam int PRUSER_W = $bits(m_apb.pruser);
   localparam int PBUSER_W = $bits(m_apb.pbuser);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state_q, state_d;

   logic [PORTS-1:0]    req;
   logic [PORTS-1:0]    unused_penable;
   logic [ADDR_W-1:0]   s_paddr  [PORTS];
   logic [2:0]          s_pprot  [PORTS];
   logic                s_pwrite [PORTS];
   logic [DATA_W-1:0]   s_pwdata [PORTS];
   logic [STRB_W-1:0]   s_pstrb  [PORTS];
   logic [PAUSER_W-1:0] s_pauser [PORTS];
   logic [PWUSER_W-1:0] s_pwuser [PORTS];

   logic [IDX_W-1:0]    grant_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    arb_win;
   logic                arb_found;
   int                  arb_base;

   logic                m_psel_q;
   logic                m_penable_q;
   logic [ADDR_W-1:0]   lat_paddr;
   logic [2:0]          lat_pprot;
   logic                lat_pwrite;
   logic [DATA_W-1:0]   lat_pwdata;
   logic [STRB_W-1:0]   lat_pstrb;
   logic [PAUSER_W-1:0] lat_pauser;
   logic [PWUSER_W-1:0] lat_pwuser;

   logic                rsp_vld;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_slverr;
   logic [PRUSER_W-1:0] rsp_ruser;
   logic [PBUSER_W-1:0] rsp_buser;

   for (genvar g = 0; g < PORTS; g++) begin : g_port
      if ($bits(s_apb[g].pwdata) != DATA_W || $bits(s_apb[g].paddr) != ADDR_W ||
          $bits(s_apb[g].pstrb) != STRB_W) begin : g_width_err
         $fatal(1, "taxi_apb_arb: s_apb width does not match m_apb");
      end

      logic rsp_hit;

      assign req[g]            = s_apb[g].psel;
      assign unused_penable[g] = s_apb[g].penable;
      assign s_paddr[g]        = s_apb[g].paddr;
      assign s_pprot[g]        = s_apb[g].pprot;
      assign s_pwrite[g]       = s_apb[g].pwrite;
      assign s_pwdata[g]       = s_apb[g].pwdata;
      assign s_pstrb[g]        = s_apb[g].pstrb;
      assign s_pauser[g]       = s_apb[g].pauser;
      assign s_pwuser[g]       = s_apb[g].pwuser;

      // Only the granted port ever sees a non-zero response.
      assign rsp_hit          = rsp_vld && (grant_q == IDX_W'(g));
      assign s_apb[g].pready  = rsp_hit;
      assign s_apb[g].pslverr = rsp_hit && rsp_slverr;
      assign s_apb[g].prdata  = rsp_hit ? rsp_rdata : '0;
      assign s_apb[g].pruser  = rsp_hit ? rsp_ruser : '0;
      assign s_apb[g].pbuser  = rsp_hit ? rsp_buser : '0;
   end

   // Search upward from the pointer with wrap; fixed priority always starts at port 0.
   always_comb begin
      arb_win   = '0;
      arb_found = 1'b0;
      arb_base  = ARB_ROUND_ROBIN ? int'(ptr_q) : 0;
      for (int k = 0; k < PORTS; k++) begin
         if (!arb_found && req[(arb_base + k) % PORTS]) begin
            arb_win   = IDX_W'((arb_base + k) % PORTS);
            arb_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (m_apb.pready) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         m_psel_q    <= 1'b0;
         m_penable_q <= 1'b0;
         rsp_vld     <= 1'b0;
         lat_paddr   <= '0;
         lat_pprot   <= '0;
         lat_pwrite  <= 1'b0;
         lat_pwdata  <= '0;
         lat_pstrb   <= '0;
         lat_pauser  <= '0;
         lat_pwuser  <= '0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_ruser   <= '0;
         rsp_buser   <= '0;
      end else begin
         state_q     <= state_d;
         m_psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
         m_penable_q <= (state_d == ACCESS);
         rsp_vld     <= (state_d == RESP);

         if (state_q == IDLE && (|req)) begin
            grant_q    <= arb_win;
            lat_paddr  <= s_paddr[arb_win];
            lat_pprot  <= s_pprot[arb_win];
            lat_pwrite <= s_pwrite[arb_win];
            lat_pwdata <= s_pwdata[arb_win];
            lat_pstrb  <= s_pstrb[arb_win];
            lat_pauser <= s_pauser[arb_win];
            lat_pwuser <= s_pwuser[arb_win];
         end

         if (state_q == ACCESS && m_apb.pready) begin
            rsp_rdata  <= m_apb.prdata;
            rsp_slverr <= m_apb.pslverr;
            rsp_ruser  <= m_apb.pruser;
            rsp_buser  <= m_apb.pbuser;
         end

         if (ARB_ROUND_ROBIN && state_q == RESP) begin
            ptr_q <= (int'(grant_q) == PORTS - 1) ? '0 : grant_q + IDX_W'(1);
         end
      end
   end

   assign m_apb.psel    = m_psel_q;
   assign m_apb.penable = m_penable_q;
   assign m_apb.paddr   = lat_paddr;
   assign m_apb.pprot   = lat_pprot;
   assign m_apb.pwrite  = lat_pwrite;
   assign m_apb.pwdata  = lat_pwdata;
   assign m_apb.pstrb   = lat_pstrb;
   assign m_apb.pauser  = lat_pauser;
   assign m_apb.pwuser  = lat_pwuser;

   assign busy        = (state_q != IDLE);
   assign grant_valid = (state_q != IDLE);
   assign grant_index = grant_q;
endmodule

// File: tb/tb_taxi_apb_arb.sv
// Bench for taxi_apb_arb: random 3-port round-robin traffic against a timestamp model,
// reset during ACCESS, and a directed 2-port fixed-priority run.
module tb_taxi_apb_arb;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- round-robin DUT, 3 ports ----------------
   taxi_apb_if s_rr [3] ();
   taxi_apb_if m_rr ();
   logic       rr_busy, rr_gv;
   logic [1:0] rr_gi;

   logic [2:0]  r_psel, r_pen, r_pwrite, r_pauser, r_pwuser;
   logic [31:0] r_paddr [3];
   logic [31:0] r_pwdata [3];
   logic [3:0]  r_pstrb [3];
   logic [2:0]  r_pprot [3];
   logic [2:0]  o_pready, o_pslverr, o_pruser, o_pbuser;
   logic [31:0] o_prdata [3];
   logic        c_pready, c_pslverr, c_pruser, c_pbuser;
   logic [31:0] c_prdata;

   for (genvar g = 0; g < 3; g++) begin : g_rr
      assign s_rr[g].psel    = r_psel[g];
      assign s_rr[g].penable = r_pen[g];
      assign s_rr[g].pwrite  = r_pwrite[g];
      assign s_rr[g].paddr   = r_paddr[g];
      assign s_rr[g].pwdata  = r_pwdata[g];
      assign s_rr[g].pstrb   = r_pstrb[g];
      assign s_rr[g].pprot   = r_pprot[g];
      assign s_rr[g].pauser  = r_pauser[g];
      assign s_rr[g].pwuser  = r_pwuser[g];
      assign o_pready[g]     = s_rr[g].pready;
      assign o_pslverr[g]    = s_rr[g].pslverr;
      assign o_prdata[g]     = s_rr[g].prdata;
      assign o_pruser[g]     = s_rr[g].pruser;
      assign o_pbuser[g]     = s_rr[g].pbuser;
   end
   assign m_rr.pready  = c_pready;
   assign m_rr.prdata  = c_prdata;
   assign m_rr.pslverr = c_pslverr;
   assign m_rr.pruser  = c_pruser;
   assign m_rr.pbuser  = c_pbuser;

   taxi_apb_arb #(.PORTS(3), .ARB_ROUND_ROBIN(1'b1)) u_rr (
      .clk(clk), .rst(rst), .s_apb(s_rr), .m_apb(m_rr),
      .busy(rr_busy), .grant_valid(rr_gv), .grant_index(rr_gi)
   );

   // ---------------- fixed-priority DUT, 2 ports ----------------
   taxi_apb_if s_fp [2] ();
   taxi_apb_if m_fp ();
   logic       fp_busy, fp_gv;
   logic [0:0] fp_gi;
   logic [1:0] f_psel, f_pready;
   logic [31:0] f_prdata0;

   for (genvar g = 0; g < 2; g++) begin : g_fp
      assign s_fp[g].psel    = f_psel[g];
      assign s_fp[g].penable = f_psel[g];
      assign s_fp[g].pwrite  = 1'b0;
      assign s_fp[g].paddr   = (g == 0) ? 32'h100 : 32'h200;
      assign s_fp[g].pwdata  = '0;
      assign s_fp[g].pstrb   = '0;
      assign s_fp[g].pprot   = '0;
      assign s_fp[g].pauser  = '0;
      assign s_fp[g].pwuser  = '0;
      assign f_pready[g]     = s_fp[g].pready;
   end
   assign f_prdata0    = s_fp[0].prdata;
   assign m_fp.pready  = 1'b1;
   assign m_fp.prdata  = 32'hA5A5_0000;
   assign m_fp.pslverr = 1'b0;
   assign m_fp.pruser  = '0;
   assign m_fp.pbuser  = '0;

   taxi_apb_arb #(.PORTS(2), .ARB_ROUND_ROBIN(1'b0)) u_fp (
      .clk(clk), .rst(rst), .s_apb(s_fp), .m_apb(m_fp),
      .busy(fp_busy), .grant_valid(fp_gv), .grant_index(fp_gi)
   );

   // ---------------- reference model (transaction timestamps) ----------------
   int         cyc, next_arb, tg, td, win, ptr;
   bit         act;
   bit [2:0]   done_flag;
   logic [73:0] exp_m;
   logic [34:0] exp_r;

   function automatic int rr_pick(input logic [2:0] req, input int base);
      for (int k = 0; k < 3; k++) if (req[(base + k) % 3]) return (base + k) % 3;
      return 0;
   endfunction

   // mode: 0 random, 1 saturate, 2 no new requests, 3 ports 0 and 1 request
   task automatic rr_step(input int mode);
      int  n;
      bit  in_setup, in_acc, in_resp, sel, want, acc_now;
      @(negedge clk);
      n        = cyc;
      in_setup = act && n == tg + 1;
      in_acc   = act && n >= tg + 2 && n <= td;
      in_resp  = act && n == td + 1;

      check("rr_busy", 96'(rr_busy), 96'(in_setup || in_acc || in_resp));
      check("rr_grant_valid", 96'(rr_gv), 96'(in_setup || in_acc || in_resp));
      if (in_setup || in_acc || in_resp) check("rr_grant_index", 96'(rr_gi), 96'(win));
      check("rr_m_psel", 96'(m_rr.psel), 96'(in_setup || in_acc));
      check("rr_m_penable", 96'(m_rr.penable), 96'(in_acc));
      if (in_setup || in_acc)
         check("rr_m_fields", 96'({m_rr.paddr, m_rr.pwdata, m_rr.pstrb, m_rr.pwrite,
                                   m_rr.pprot, m_rr.pauser, m_rr.pwuser}), 96'(exp_m));
      for (int p = 0; p < 3; p++) begin
         sel = in_resp && p == win;
         check($sformatf("rr_s_pready%0d", p), 96'(o_pready[p]), 96'(sel));
         check($sformatf("rr_s_rsp%0d", p),
               96'({o_prdata[p], o_pslverr[p], o_pruser[p], o_pbuser[p]}),
               sel ? 96'(exp_r) : 96'(0));
      end

      // requesters: retire last cycle's completions, then maybe issue new transfers
      for (int p = 0; p < 3; p++) begin
         if (done_flag[p]) begin
            done_flag[p] = 1'b0;
            r_psel[p]    = 1'b0;
            r_pen[p]     = 1'b0;
         end else if (r_psel[p]) begin
            r_pen[p] = 1'b1;
         end
         if (mode == 0 && in_acc && p == win && $urandom_range(0, 15) == 0) begin
            r_psel[p] = 1'b0;
            r_pen[p]  = 1'b0;
         end
         case (mode)
            0:       want = ($urandom_range(0, 2) == 0);
            1:       want = 1'b1;
            3:       want = (p < 2);
            default: want = 1'b0;
         endcase
         if (want && !r_psel[p] && !(act && p == win)) begin
            r_psel[p]   = 1'b1;
            r_pen[p]    = 1'b0;
            r_paddr[p]  = $urandom & 32'hFFFF_FFFC;
            r_pwdata[p] = $urandom;
            r_pstrb[p]  = 4'($urandom);
            r_pprot[p]  = 3'($urandom);
            r_pwrite[p] = 1'($urandom);
            r_pauser[p] = 1'($urandom);
            r_pwuser[p] = 1'($urandom);
         end
      end

      if (in_resp) begin
         done_flag[win] = 1'b1;
         ptr            = (win + 1) % 3;
         act            = 1'b0;
         next_arb       = n + 1;
      end

      if (!act && n >= next_arb && r_psel != 3'b000) begin
         win   = rr_pick(r_psel, ptr);
         tg    = n;
         td    = n + 2 + int'($urandom_range(0, 3));
         act   = 1'b1;
         exp_m = {r_paddr[win], r_pwdata[win], r_pstrb[win], r_pwrite[win],
                  r_pprot[win], r_pauser[win], r_pwuser[win]};
         exp_r = {$urandom, 1'($urandom), 1'($urandom), 1'($urandom)};
      end

      // completer: random pready/data outside ACCESS must be ignored
      acc_now = act && n >= tg + 2 && n <= td;
      if (acc_now && n == td) begin
         c_pready  = 1'b1;
         {c_prdata, c_pslverr, c_pruser, c_pbuser} = exp_r;
      end else begin
         c_pready  = acc_now ? 1'b0 : 1'($urandom);
         c_prdata  = $urandom;
         c_pslverr = 1'($urandom);
         c_pruser  = 1'($urandom);
         c_pbuser  = 1'($urandom);
      end
      cyc++;
   endtask

   initial begin
      bit reached;
      rst = 1'b1;
      r_psel = '0; r_pen = '0; r_pwrite = '0; r_pauser = '0; r_pwuser = '0;
      for (int p = 0; p < 3; p++) begin
         r_paddr[p] = '0; r_pwdata[p] = '0; r_pstrb[p] = '0; r_pprot[p] = '0;
      end
      c_pready = 1'b0; c_prdata = '0; c_pslverr = 1'b0; c_pruser = 1'b0; c_pbuser = 1'b0;
      f_psel = 2'b00;
      cyc = 0; next_arb = 0; tg = 0; td = 0; win = 0; ptr = 0; act = 1'b0; done_flag = '0;
      exp_m = '0; exp_r = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 96'(rr_busy), 96'(0));
      check("rst_grant", 96'({rr_gv, rr_gi}), 96'(0));
      check("rst_m_ctrl", 96'({m_rr.psel, m_rr.penable}), 96'(0));
      check("rst_m_data", 96'({m_rr.paddr, m_rr.pwdata, m_rr.pstrb}), 96'(0));
      check("rst_s_pready", 96'(o_pready), 96'(0));
      rst = 1'b0;

      repeat (300) rr_step(0);
      repeat (100) rr_step(1);

      // steer into ACCESS of a transfer after which the pointer is 1
      reached = 1'b0;
      for (int k = 0; k < 60 && !reached; k++) begin
         if (act && cyc >= tg + 2 && cyc < td && ptr == 1) reached = 1'b1;
         else rr_step(1);
      end
      check("rst_reach_access", 96'(reached), 96'(1));
      @(negedge clk);
      rst      = 1'b1;
      c_pready = 1'b0;
      cyc++;
      @(negedge clk);
      check("midrst_m_ctrl", 96'({m_rr.psel, m_rr.penable}), 96'(0));
      check("midrst_busy", 96'({rr_busy, rr_gv}), 96'(0));
      check("midrst_s_pready", 96'(o_pready), 96'(0));
      rst = 1'b0;
      r_psel = '0; r_pen = '0;
      act = 1'b0; ptr = 0; done_flag = '0; next_arb = 0;
      cyc++;
      rr_step(3);
      repeat (14) rr_step(2);

      // fixed priority: port 0 hogs until it lets go
      for (int n = 0; n < 32; n++) begin
         bit exp_psel;
         @(negedge clk);
         exp_psel = (n < 24 && (n % 4 == 1 || n % 4 == 2)) || n == 25 || n == 26;
         check("fp_pready0", 96'(f_pready[0]), 96'(n < 24 && n % 4 == 3));
         check("fp_pready1", 96'(f_pready[1]), 96'(n == 27));
         check("fp_prdata0", 96'(f_prdata0), (n < 24 && n % 4 == 3) ? 96'(32'hA5A5_0000) : 96'(0));
         check("fp_m_psel", 96'(m_fp.psel), 96'(exp_psel));
         check("fp_busy", 96'({fp_busy, fp_gv}),
               (n < 24 ? n % 4 != 0 : (n >= 25 && n <= 27)) ? 96'(3) : 96'(0));
         if (exp_psel) check("fp_m_paddr", 96'(m_fp.paddr), n < 24 ? 96'(32'h100) : 96'(32'h200));
         if (n < 28 && n % 4 != 0) check("fp_grant_index", 96'(fp_gi), 96'(n >= 24));
         if (n == 0)  f_psel    = 2'b11;
         if (n == 24) f_psel[0] = 1'b0;
         if (n == 28) f_psel[1] = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end
endmodule
